tt_response_checker: RTL and testbench

Sequential response checker for 3-input combinational lab circuits. On `start` it drives all eight input combinations onto `a`/`b`/`c` in ascending order. For each combination it waits a settle interval, samples the circuit's single output `f`, and compares it against an expected 8-entry truth table. It sits beside the circuit under test on the lab board: this block drives the stimulus and reads back the result, then reports pass/fail and a per-row mismatch mask.

---
 rtl/tt_response_checker_pkg.sv | 15 +
 rtl/tt_response_checker_if.sv | 26 ++
 rtl/tt_response_checker_settle_timer.sv | 27 ++
 rtl/tt_response_checker.sv | 116 +++++++++++
 tb/tb_tt_response_checker.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/tt_response_checker_pkg.sv
// Shared types and widths for the truth-table response checker.
package tt_check_pkg;

  localparam int TT_W     = 8;
  localparam int IDX_W    = 3;
  localparam int SETTLE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tt_response_checker_if.sv
// Bus between the response checker and whatever drives/observes it.
// start is a single-cycle request with no ready: it is accepted only when
// busy=0 (IDLE or DONE) and silently dropped while busy=1.
interface tt_check_if;
  logic                        start;
  logic [tt_check_pkg::TT_W-1:0] exp_tt;
  logic                        f;
  logic                        a;
  logic                        b;
  logic                        c;
  logic                        busy;
  logic                        done;
  logic                        pass;
  logic [tt_check_pkg::TT_W-1:0] fail_mask;
  logic [3:0]                  fail_count;

  modport master (
    output start, exp_tt, f,
    input  a, b, c, busy, done, pass, fail_mask, fail_count
  );

  modport slave (
    input  start, exp_tt, f,
    output a, b, c, busy, done, pass, fail_mask, fail_count
  );
endinterface

// File: rtl/tt_response_checker_settle_timer.sv
// Loadable down-counter: clear loads LOAD, en counts down to zero and stops.
module settle_timer #(
  parameter int W    = 8,
  parameter int LOAD = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= W'(LOAD);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tt_response_checker.sv
// Sweeps {a,b,c} through 000..111, samples f after a settle interval and
// accumulates a per-row mismatch mask against a latched truth table.
module tt_response_checker
  import tt_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  tt_check_if.slave    bus,
  output state_e       state_o
);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TT_W-1:0]   tt_q;
  logic [TT_W-1:0]   mask_q;
  logic [3:0]        count_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;

  logic [TT_W-1:0]   mask_d;
  logic [3:0]        count_d;
  logic              accept;
  logic              mismatch;
  logic              tmr_clear;
  logic              tmr_en;
  logic              tmr_expired;

  assign accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch = (bus.f != tt_q[idx_q]);

  always_comb begin
    mask_d  = mask_q;
    count_d = count_q;
    if (mismatch) begin
      mask_d[idx_q] = 1'b1;
      count_d       = count_q + 4'd1;
    end
  end

  // Timer is reloaded when a vector is first driven, so it counts the
  // SETTLE cycles of every row.
  assign tmr_clear = accept || (state_q == SAMPLE);
  assign tmr_en    = (state_q == SETTLE);

  settle_timer #(
    .W    (SETTLE_W),
    .LOAD (SETTLE_CYCLES - 1)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      tt_q    <= '0;
      mask_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            tt_q    <= bus.exp_tt;
            idx_q   <= '0;
            mask_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (tmr_expired) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          mask_q  <= mask_d;
          count_q <= count_d;
          if (&idx_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (mask_d == '0);
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 3'd1;
            state_q <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a          = idx_q[2];
  assign bus.b          = idx_q[1];
  assign bus.c          = idx_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_mask  = mask_q;
  assign bus.fail_count = count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Self-checking bench for tt_response_checker: table vectors, corner
// sequences and randomized tables against a truth-table model.
module tb_tt_response_checker;
  import tt_check_pkg::*;

  localparam int S   = 4;
  localparam int LAT = 8 * (S + 1);

  logic       clk;
  logic       rst;
  logic [7:0] ckt_tt;
  logic       noise;
  state_e     state_dbg;

  int checks;
  int errors;

  tt_check_if bus ();

  tt_response_checker #(.SETTLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // Circuit under test: a lookup table on {a,b,c}, optionally glitched.
  assign bus.f = ckt_tt[{bus.a, bus.b, bus.c}] ^ noise;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] et;
    logic [7:0] ct;
    logic [7:0] mask;
    logic [3:0] cnt;
    logic       pss;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_sweep(input string nm, input logic [7:0] et, input logic [7:0] ct,
                           input bit xs, input bit chg, input bit glitch,
                           input logic [7:0] emask, input logic [3:0] ecnt, input logic epass);
    int lat;
    int bad;
    logic [2:0] exp_abc;
    ckt_tt = ct;
    noise  = 1'b0;
    @(negedge clk);
    bus.exp_tt = et;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({nm, "_done_drop"}, 32'(bus.done), 32'd0);
    lat = 0;
    bad = 0;
    while (!bus.done && lat < LAT + 20) begin
      exp_abc = 3'(lat / (S + 1));
      if ({bus.a, bus.b, bus.c} !== exp_abc || bus.busy !== 1'b1 || bus.pass !== 1'b0) bad++;
      // f may glitch freely except in the cycle that ends at a sample edge
      noise = (glitch && ((lat + 1) % (S + 1) != 0)) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      bus.start = xs && (lat == 7 || lat == 22);
      if (chg && lat == 10) bus.exp_tt = 8'h00;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    noise     = 1'b0;
    check({nm, "_latency"},    32'(lat),        32'(LAT));
    check({nm, "_during"},     32'(bad),        32'd0);
    check({nm, "_mask"},       32'(bus.fail_mask),  32'(emask));
    check({nm, "_count"},      32'(bus.fail_count), 32'(ecnt));
    check({nm, "_pass"},       32'(bus.pass),   32'(epass));
    check({nm, "_busy_end"},   32'(bus.busy),   32'd0);
    check({nm, "_abc_end"},    32'({bus.a, bus.b, bus.c}), 32'd7);
  endtask

  initial begin
    logic [7:0] r_et;
    logic [7:0] r_ct;
    logic [7:0] m_mask;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.exp_tt = 8'h00;
    ckt_tt     = 8'h00;
    noise      = 1'b0;

    vecs[0] = '{et: 8'hE8, ct: 8'hE8, mask: 8'h00, cnt: 4'd0, pss: 1'b1};
    vecs[1] = '{et: 8'hE8, ct: 8'h00, mask: 8'hE8, cnt: 4'd4, pss: 1'b0};
    vecs[2] = '{et: 8'hE8, ct: 8'h80, mask: 8'h68, cnt: 4'd3, pss: 1'b0};
    vecs[3] = '{et: 8'hFF, ct: 8'hFF, mask: 8'h00, cnt: 4'd0, pss: 1'b1};
    vecs[4] = '{et: 8'h00, ct: 8'hFF, mask: 8'hFF, cnt: 4'd8, pss: 1'b0};
    vecs[5] = '{et: 8'h5A, ct: 8'hA5, mask: 8'hFF, cnt: 4'd8, pss: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    check("rst_pass",  32'(bus.pass), 32'd0);
    check("rst_abc",   32'({bus.a, bus.b, bus.c}), 32'd0);
    check("rst_mask",  32'(bus.fail_mask), 32'd0);
    check("rst_count", 32'(bus.fail_count), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_sweep($sformatf("vec%0d", i), vecs[i].et, vecs[i].ct, 1'b0, 1'b0, 1'b0,
                vecs[i].mask, vecs[i].cnt, vecs[i].pss);
    end

    run_sweep("extra_start", 8'hE8, 8'hE8, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
    run_sweep("tt_change",   8'hE8, 8'hE8, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1);
    run_sweep("glitch",      8'hE8, 8'h80, 1'b0, 1'b0, 1'b1, 8'h68, 4'd3, 1'b0);

    // Reset in the middle of row 3, with a start in the same cycle.
    ckt_tt = 8'hE8;
    @(negedge clk);
    bus.exp_tt = 8'hE8;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3 * (S + 1)) @(posedge clk);
    #1;
    check("midrst_pre_abc", 32'({bus.a, bus.b, bus.c}), 32'd3);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_abc",  32'({bus.a, bus.b, bus.c}), 32'd0);
    check("midrst_mask", 32'(bus.fail_mask), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_count", 32'(bus.fail_count), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_idle", 32'(bus.busy), 32'd0);
    run_sweep("after_rst", 8'hE8, 8'hE8, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);

    // Random tables: the mask is simply the rows where circuit and table disagree.
    for (int n = 0; n < 8; n++) begin
      r_et   = 8'($urandom);
      r_ct   = (n % 3 == 0) ? r_et : 8'($urandom);
      m_mask = r_et ^ r_ct;
      run_sweep($sformatf("rand%0d", n), r_et, r_ct, 1'b0, 1'b0, n[0], m_mask,
                4'($countones(m_mask)), (m_mask == 8'h00));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
